led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer_if.sv | 35 +++
 rtl/led_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/led_sequencer_if.sv
// LED sequencer control/status bundle.
// master: drives start/stop, run parameters and the pattern write port; observes the display.
// slave : the sequencer itself.
//   start, stop         single-cycle run control
//   mode, len, div      run parameters, sampled on an accepted start
//   wr_en/addr/data     pattern memory write port
//   leds, idx           registered pattern and its index
//   busy, done          running flag, once-mode completion pulse
interface led_sequencer_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DIV_W = 21
);
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [3:0]       len;
  logic [DIV_W-1:0] div;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] leds;
  logic [3:0]       idx;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, mode, len, div, wr_en, wr_addr, wr_data,
    input  leds, idx, busy, done
  );

  modport slave (
    input  start, stop, mode, len, div, wr_en, wr_addr, wr_data,
    output leds, idx, busy, done
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: steps through a small pattern memory at a programmable rate in
// once, loop or ping-pong order.
// Ports:
//   clk_i   sole clock, rising edge
//   rst_i   asynchronous active-high reset (pattern memory is not reset)
//   bus_io  led_sequencer_if.slave: start/stop, mode/len/div, write port, leds/idx/busy/done
module led_sequencer #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 12,
  parameter int unsigned DIV_W = 21
) (
  input  logic           clk_i,
  input  logic           rst_i,
  led_sequencer_if.slave bus_io
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [1:0] ModeOnce = 2'b00;
  localparam logic [1:0] ModePing = 2'b10;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       last_q, last_d;      // effective length minus one
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             dir_q, dir_d;        // 0 = up, 1 = down
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [3:0] start_last;
  logic [3:0] step_idx;
  logic       step_dir;
  logic       step_fin;
  logic       step_load;

  // Pattern memory: no reset, writable in any state. Reads below see the pre-write contents,
  // so a step that loads the address being written shows the old data.
  always_ff @(posedge clk_i) begin
    if (bus_io.wr_en && (32'(bus_io.wr_addr) < DEPTH)) begin
      mem_q[bus_io.wr_addr] <= bus_io.wr_data;
    end
  end

  // Clamp requested length to 1..DEPTH and keep it as a last index.
  always_comb begin
    if (bus_io.len == 4'd0) begin
      start_last = 4'd0;
    end else if (32'(bus_io.len) > DEPTH) begin
      start_last = 4'(DEPTH - 1);
    end else begin
      start_last = bus_io.len - 4'd1;
    end
  end

  // Index/direction that the next step moves to.
  always_comb begin
    step_idx  = idx_q;
    step_dir  = dir_q;
    step_fin  = 1'b0;
    step_load = 1'b1;
    unique case (mode_q)
      ModeOnce: begin
        if (idx_q == last_q) begin
          step_fin  = 1'b1;
          step_load = 1'b0;
        end else begin
          step_idx = idx_q + 4'd1;
        end
      end
      ModePing: begin
        if (last_q == 4'd0) begin
          step_load = 1'b0;
        end else if (!dir_q) begin
          if (idx_q == last_q) begin
            // Reverse and move so the endpoint is not shown twice in a row.
            step_dir = 1'b1;
            step_idx = idx_q - 4'd1;
          end else begin
            step_idx = idx_q + 4'd1;
          end
        end else begin
          if (idx_q == 4'd0) begin
            step_dir = 1'b0;
            step_idx = 4'd1;
          end else begin
            step_idx = idx_q - 4'd1;
          end
        end
      end
      default: begin
        // Loop, and the reserved encoding behaves as loop.
        step_idx = (idx_q == last_q) ? 4'd0 : idx_q + 4'd1;
      end
    endcase
  end

  // Next state. STOP takes priority over START; STOP while idle does nothing.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    last_d  = last_q;
    div_d   = div_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    leds_d  = leds_q;
    done_d  = 1'b0;

    if (bus_io.stop) begin
      if (state_q == StRun) begin
        state_d = StIdle;
        presc_d = '0;
        dir_d   = 1'b0;
        idx_d   = 4'd0;
        leds_d  = '0;
      end
    end else if (bus_io.start) begin
      state_d = StRun;
      mode_d  = bus_io.mode;
      last_d  = start_last;
      div_d   = bus_io.div;
      presc_d = '0;
      dir_d   = 1'b0;
      idx_d   = 4'd0;
      leds_d  = mem_q[0];
    end else if (state_q == StRun) begin
      if (presc_q == div_q) begin
        presc_d = '0;
        if (step_fin) begin
          // Once-mode completion: leave the last pattern on display.
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          dir_d = step_dir;
          idx_d = step_idx;
          if (step_load) begin
            leds_d = mem_q[step_idx];
          end
        end
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= 2'b00;
      last_q  <= 4'd0;
      div_q   <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      idx_q   <= 4'd0;
      leds_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
    end
  end

  assign bus_io.leds = leds_q;
  assign bus_io.idx  = idx_q;
  assign bus_io.busy = (state_q == StRun);
  assign bus_io.done = done_q;

endmodule
